// File: rtl/dm_access_pkg.sv
// Shared op encodings, FSM states and alignment helpers for the data-memory access unit.
package dm_access_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_SW  = 3'd3,
    OP_LBU = 3'd4,
    OP_LHU = 3'd5,
    OP_SB  = 3'd6,
    OP_SH  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Byte offset rounded down to the natural alignment of the access size.
  function automatic logic [1:0] align_off(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: align_off = {off[1], 1'b0};
      OP_LW, OP_SW:         align_off = 2'b00;
      default:              align_off = off;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    misaligned = (align_off(op, off) != off);
  endfunction

  function automatic logic is_sub_store(input logic [2:0] op);
    is_sub_store = (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic: little-endian load extract/extend and sub-word store merge.
module dm_lane_align
  import dm_access_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [4:0]  bit_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign bit_off  = {off_i, 3'b000};
  assign byte_sel = word_i[bit_off +: 8];
  assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    load_data_o = '0;
    case (op_i)
      OP_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data_o = {24'd0, byte_sel};
      OP_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data_o = {16'd0, half_sel};
      OP_LW:   load_data_o = word_i;
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    merge_data_o = word_i;
    case (op_i)
      OP_SB: merge_data_o[bit_off +: 8] = wdata_i[7:0];
      OP_SH: begin
        if (off_i[1]) merge_data_o[31:16] = wdata_i[15:0];
        else          merge_data_o[15:0]  = wdata_i[15:0];
      end
      OP_SW:   merge_data_o = wdata_i;
      default: merge_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// CPU-side data-memory initiator: byte/half/word loads and stores over a word memory, RMW for sb/sh.
// DM_MISALIGN_TRAP_EN: misaligned accesses respond with rsp_err instead of being aligned down.
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  input  logic [31:0]       mem_dout
);

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       din_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [1:0]        req_off;
  logic              req_trap;
  logic              accept;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign req_off     = align_off(req_op, req_addr[1:0]);
  assign accept      = (state_q == ST_IDLE) && req_valid;

`ifdef DM_MISALIGN_TRAP_EN
  logic err_q;
  assign req_trap = misaligned(req_op, req_addr[1:0]);
  assign rsp_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= req_trap;
  end
`else
  assign req_trap = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  dm_lane_align u_lane_align (
    .op_i         (op_q),
    .off_i        (off_q),
    .word_i       (mem_dout),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // mem_we is decoded from state so an async reset removes it before the negedge write.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_trap ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (op_q == OP_SW) begin
          mem_we  = 1'b1;
          state_d = ST_RESP;
        end else if (is_sub_store(op_q)) begin
          state_d = ST_MERGE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_MERGE: begin
        mem_we  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_LB;
      off_q   <= 2'b00;
      wdata_q <= '0;
      rdata_q <= RST_DATA;
      din_q   <= RST_DATA;
      maddr_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        off_q   <= req_off;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        maddr_q <= req_addr[ADDR_W+1:2];
        if (req_op == OP_SW) din_q <= req_wdata;
      end
      // Stores yield zero from the lane logic, so rsp_rdata is 0 for them.
      if (state_q == ST_ACCESS) begin
        rdata_q <= load_data;
        if (is_sub_store(op_q)) din_q <= merge_data;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign mem_addr  = maddr_q;
  assign mem_din   = din_q;

endmodule
